mips_gpio_in: RTL and testbench
===============================

# mips_gpio_in

Memory-mapped GPIO input peripheral for the multi-cycle MIPS core, the input-direction counterpart of the core's `GPIO_o` output port. It synchronizes and debounces external input pins and latches sticky rising and falling edge flags. The debounced level and the flags are exposed as CPU-readable registers, and an optional level interrupt is raised from the flags. It sits on the core's data-memory bus next to the output port and responds to word-aligned accesses in its 16-byte window.

## Interface
- `WIDTH`, default 8: number of input pins, 1..32.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced level changes; must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `GPIO_i`  in  WIDTH  asynchronous external pins.
- `sel`  in  1  chip select from the address decoder.
- `we`  in  1  write enable; valid only when `sel`=1.
- `addr`  in  2  word offset, bus address bits [3:2].
- `wdata`  in  32  write data.
- `rdata`  out  32  read data.
- `irq`  out  1  registered level interrupt.

## Operation
- **Register map** (offset → register):
  - 0x0 DATA: read-only, debounced level.
  - 0x4 RISE: sticky rising-edge flags, write-1-to-clear.
  - 0x8 FALL: sticky falling-edge flags, write-1-to-clear.
  - 0xC IRQ_EN: read/write, per-bit interrupt mask.
- **Unused and ignored bits:**
  - Bits [31:WIDTH] read as 0.
  - Writes to DATA are ignored.
  - Bits of `wdata` above WIDTH are ignored.
- **Synchronizer:** two flops per bit, `s1` ← `GPIO_i`, then `s2` ← `s1`.
- **Debounce, per bit:**
  - Keeps a counter of width $clog2(DEBOUNCE_CYCLES+1) and a debounced flop `db`.
  - If `s2` == `db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, `db` takes the value of `s2` and the counter clears.
  - The counter never wraps; any glitch shorter than DEBOUNCE_CYCLES cycles restarts it.
- **Edge flags:**
  - RISE[i] sets on the edge where `db`[i] goes 0→1.
  - FALL[i] sets on the edge where `db`[i] goes 1→0.
  - Writing 1 clears a flag; writing 0 leaves it unchanged.
  - If a set and a clear hit the same flag on the same edge, the set wins and the flag stays 1.
- **Interrupt:** `irq` ← |((RISE | FALL) & IRQ_EN), registered.
- **Read path:** `rdata` is combinational from registered state.
  - Selected register when `sel`=1 and `we`=0.
  - 0 otherwise.
- **Reset:** asserting `reset` clears `s1`, `s2`, `db`, all counters, RISE, FALL and IRQ_EN, and forces `irq`=0.
  - Asserting `reset` mid-debounce discards the pending change.
  - After release, a pin that is high must re-qualify through the full debounce and produces a RISE flag.

## Timing
- **Reset values:** `rdata`=0 and `irq`=0.
- **Pin-to-level latency:** `GPIO_i` changes and is stable before edge 1.
  - `s2` reflects the change after edge 2.
  - `db` and the edge flag update at edge 2+DEBOUNCE_CYCLES, i.e. edge 6 for the default.
  - `irq` asserts at edge 3+DEBOUNCE_CYCLES when the bit is enabled.
- **Bus accesses:**
  - Reads have zero wait states; `rdata` is valid in the same cycle as `sel`.
  - Writes take effect at the clock edge where `sel`=`we`=1.
  - `irq` deasserts one edge after the flag-clearing write or the IRQ_EN write.
- **Simultaneous events:**
  - A write-1-to-clear and a new edge on the same bit in the same cycle leave the flag set.
  - A rising edge on one bit and a clear of another bit in the same cycle are independent.
- No back-pressure and no handshake: every bus access completes in one cycle.

## Test plan
- **Reset defaults:** hold `reset`=0 while driving `GPIO_i`=8'hFF, then release.
  - While `reset`=0: reads of all four registers return 0 and `irq`=0.
  - DATA reads 8'hFF from edge 6 after release.
  - RISE reads 8'hFF.
- **Debounce latency:** `GPIO_i`[0] 0→1 before edge 1.
  - DATA[0]=0 through edge 5, 1 after edge 6.
  - RISE=8'h01.
  - FALL=8'h00.
- **Glitch reject:** pulse `GPIO_i`[3] high for 3 cycles (DEBOUNCE_CYCLES=4).
  - DATA, RISE and FALL stay 8'h00.
  - A 4-cycle stable pulse sets RISE[3]=1, then FALL[3]=1 after it ends.
- **W1C and collision:**
  - Write RISE=8'h01 with RISE=8'h05: RISE reads 8'h04.
  - Write 8'h04 on the same edge `db`[2] re-rises: RISE[2] stays 1.
- **Interrupt:** IRQ_EN=8'h02 and a falling edge on bit 1.
  - `irq`=1 one cycle after FALL[1] sets.
  - Writing FALL=8'h02 drops `irq` one edge later.
  - An edge on bit 0 with IRQ_EN[0]=0 keeps `irq`=0.
- **Reset mid-debounce:** assert `reset` two cycles into a qualifying high on bit 5, then release with the pin still high.
  - DATA[5] rises exactly 2+DEBOUNCE_CYCLES edges after release.
  - No stale flag remains.

Source files
------------

// File: rtl/mips_gpio_in.sv
// GPIO input peripheral for the multi-cycle MIPS data bus: two-flop synchronizer,
// per-bit debounce, sticky write-1-to-clear edge flags and a maskable level interrupt.
module mips_gpio_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] GPIO_i,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_RISE   = 2'd1,
    REG_FALL   = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_e;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_rise, clr_fall;
  logic             unused_wdata;

  assign wr_en        = sel & we;
  assign wr_bits      = wdata[WIDTH-1:0];
  assign clr_rise     = (wr_en && reg_e'(addr) == REG_RISE) ? wr_bits : '0;
  assign clr_fall     = (wr_en && reg_e'(addr) == REG_FALL) ? wr_bits : '0;
  assign unused_wdata = ^wdata;

  // A counter only advances while s2 disagrees with db; reaching the last step
  // commits the new level, so any disagreement run shorter than the threshold is lost.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // New edges are OR'd in after the clear so a colliding set always wins.
  always_comb begin
    rise_d   = (rise_q & ~clr_rise) | (db_d & ~db_q);
    fall_d   = (fall_q & ~clr_fall) | (~db_d & db_q);
    irq_en_d = irq_en_q;
    if (wr_en && reg_e'(addr) == REG_IRQ_EN) begin
      irq_en_d = wr_bits;
    end
    irq_d = |((rise_q | fall_q) & irq_en_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= GPIO_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel && !we) begin
      case (reg_e'(addr))
        REG_DATA:   rdata = 32'(db_q);
        REG_RISE:   rdata = 32'(rise_q);
        REG_FALL:   rdata = 32'(fall_q);
        REG_IRQ_EN: rdata = 32'(irq_en_q);
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mips_gpio_in.sv
// Bench for mips_gpio_in: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a sample-history reference model.
module tb_mips_gpio_in;

  localparam int W   = 8;
  localparam int DEB = 4;

  logic        clk;
  logic        reset;
  logic [7:0]  gpio;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int compared;
  int mismatched;
  bit checking;

  mips_gpio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset  (reset),
    .GPIO_i (gpio),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the debounced level flips once the last DEB synchronized
  // samples all disagree with it; flags and interrupt follow from level changes.
  logic [7:0] mS1, mS2, mDb, mRise, mFall, mEn, nextDb, clrR, clrF;
  logic       mIrq, allDiff;
  logic [7:0] hist[$];

  always @(posedge clk) begin
    if (!reset) begin
      mS1 = '0; mS2 = '0; mDb = '0; mRise = '0; mFall = '0; mEn = '0; mIrq = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(mS2);
      if (hist.size() > DEB) void'(hist.pop_front());
      nextDb = mDb;
      if (hist.size() == DEB) begin
        for (int i = 0; i < W; i++) begin
          allDiff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == mDb[i]) allDiff = 1'b0;
          if (allDiff) nextDb[i] = ~mDb[i];
        end
      end
      clrR = (sel && we && addr == 2'd1) ? wdata[7:0] : 8'h00;
      clrF = (sel && we && addr == 2'd2) ? wdata[7:0] : 8'h00;
      mIrq  = |((mRise | mFall) & mEn);
      mRise = (mRise & ~clrR) | (nextDb & ~mDb);
      mFall = (mFall & ~clrF) | (~nextDb & mDb);
      if (sel && we && addr == 2'd3) mEn = wdata[7:0];
      mDb = nextDb;
      mS2 = mS1;
      mS1 = gpio;
    end
  end

  function automatic logic [31:0] expRdata();
    logic [7:0] v;
    if (!(sel && !we)) return 32'h0;
    case (addr)
      2'd0:    v = mDb;
      2'd1:    v = mRise;
      2'd2:    v = mFall;
      default: v = mEn;
    endcase
    return {24'h0, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (checking) begin
        checkOutput("model_rdata", rdata, expRdata());
        checkOutput("model_irq", {31'h0, irq}, {31'h0, mIrq});
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; wdata = d;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic readExpect(input string name, input logic [1:0] a, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    #1;
    checkOutput(name, rdata, exp);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic clearFlags();
    writeReg(2'd1, 32'hFFFF_FFFF);
    writeReg(2'd2, 32'hFFFF_FFFF);
  endtask

  int holdLeft;

  initial begin
    compared = 0; mismatched = 0; checking = 1'b0;
    reset = 1'b0; gpio = 8'hFF;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    waitCycles(3);
    checking = 1'b1;

    readExpect("rst_data", 2'd0, 32'h0);
    readExpect("rst_rise", 2'd1, 32'h0);
    readExpect("rst_fall", 2'd2, 32'h0);
    readExpect("rst_irqen", 2'd3, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);

    reset = 1'b1;
    waitCycles(5);
    readExpect("rel_data_e5", 2'd0, 32'h00);
    waitCycles(1);
    readExpect("rel_data_e6", 2'd0, 32'hFF);
    readExpect("rel_rise", 2'd1, 32'hFF);
    readExpect("rel_fall", 2'd2, 32'h00);

    gpio = 8'h00;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    waitCycles(10);
    clearFlags();

    gpio = 8'h01;
    waitCycles(5);
    readExpect("deb_data_e5", 2'd0, 32'h00);
    waitCycles(1);
    readExpect("deb_data_e6", 2'd0, 32'h01);
    readExpect("deb_rise", 2'd1, 32'h01);
    readExpect("deb_fall", 2'd2, 32'h00);

    gpio = 8'h00;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    waitCycles(10);
    clearFlags();
    gpio = 8'h08;
    waitCycles(3);
    gpio = 8'h00;
    waitCycles(10);
    readExpect("glitch_data", 2'd0, 32'h00);
    readExpect("glitch_rise", 2'd1, 32'h00);
    readExpect("glitch_fall", 2'd2, 32'h00);
    gpio = 8'h08;
    waitCycles(4);
    gpio = 8'h00;
    waitCycles(4);
    readExpect("pulse_rise", 2'd1, 32'h08);
    readExpect("pulse_fall_early", 2'd2, 32'h00);
    waitCycles(4);
    readExpect("pulse_fall", 2'd2, 32'h08);

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    clearFlags();
    gpio = 8'h05;
    waitCycles(8);
    readExpect("w1c_before", 2'd1, 32'h05);
    writeReg(2'd1, 32'hFFFF_FF01);
    readExpect("w1c_after", 2'd1, 32'h04);
    gpio = 8'h01;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    waitCycles(10);
    gpio = 8'h05;
    waitCycles(5);
    writeReg(2'd1, 32'h0000_0004);
    readExpect("collide_rise", 2'd1, 32'h04);
    readExpect("collide_data", 2'd0, 32'h05);

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    clearFlags();
    gpio = 8'h07;
    waitCycles(10);
    writeReg(2'd1, 32'hFF);
    checkOutput("irq_masked", {31'h0, irq}, 32'h0);
    writeReg(2'd3, 32'h02);
    readExpect("irqen_rd", 2'd3, 32'h02);
    gpio = 8'h05;
    waitCycles(6);
    readExpect("irq_fall_set", 2'd2, 32'h02);
    checkOutput("irq_e6", {31'h0, irq}, 32'h0);
    waitCycles(1);
    checkOutput("irq_e7", {31'h0, irq}, 32'h1);
    writeReg(2'd2, 32'h02);
    checkOutput("irq_clr_edge", {31'h0, irq}, 32'h1);
    waitCycles(1);
    checkOutput("irq_clr_next", {31'h0, irq}, 32'h0);
    gpio = 8'h04;
    waitCycles(10);
    readExpect("irq_b0_fall", 2'd2, 32'h01);
    checkOutput("irq_b0_masked", {31'h0, irq}, 32'h0);

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    clearFlags();
    gpio = 8'h24;
    waitCycles(4);
    readExpect("mid_pre_data", 2'd0, 32'h04);
    reset = 1'b0;
    waitCycles(2);
    reset = 1'b1;
    waitCycles(5);
    readExpect("mid_data_e5", 2'd0, 32'h00);
    waitCycles(1);
    readExpect("mid_data_e6", 2'd0, 32'h24);
    readExpect("mid_rise", 2'd1, 32'h24);
    readExpect("mid_fall", 2'd2, 32'h00);
    readExpect("mid_irqen", 2'd3, 32'h00);

    holdLeft = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (holdLeft == 0) begin
        gpio = gpio ^ (8'($urandom) & 8'($urandom));
        holdLeft = $urandom_range(1, 9);
      end
      holdLeft--;
      applyStimulus(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), $urandom);
      reset = ($urandom_range(0, 299) != 0);
    end

    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    waitCycles(2);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
